riscv_lsu_axi_bridge: RTL and testbench

- Sits directly downstream of the load/store unit and replaces direct simulation memory access with an AXI4-Lite master port.
- Accepts one load or store request at a time over a valid/ready interface.
- Generates byte strobes and lane-replicated write data, and lane-aligns read data to bit 0.
- Returns one response per request. Sign/zero extension stays in the LSU.

---
 rtl/riscv_lsu_axi_bridge.sv | 182 ++++++++++++++++++
 tb/tb_riscv_lsu_axi_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_axi_bridge.sv
// LSU request -> AXI4-Lite master bridge; one transaction in flight, zero-wait load/store response 3 cycles after accept.
// Backpressure: req_ready only in IDLE, AXI valids held until handshake, response held until rsp_ready.
module riscv_lsu_axi_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wen,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [1:0]              req_size,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [1:0]              m_bresp,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic                    arvalid_q;
  logic                    rready_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    bready_q;

  logic                    misalign_d;
  logic [DATA_WIDTH/8-1:0] strb_d;
  logic [DATA_WIDTH-1:0]   wdata_d;
  logic                    aw_done;
  logic                    w_done;

  always_comb begin
    misalign_d = 1'b1;
    strb_d     = 4'b1111;
    wdata_d    = req_wdata;
    case (req_size)
      2'd0: begin
        misalign_d = 1'b0;
        strb_d     = 4'b0001 << req_addr[1:0];
        wdata_d    = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misalign_d = req_addr[0];
        strb_d     = 4'b0011 << req_addr[1:0];
        wdata_d    = {2{req_wdata[15:0]}};
      end
      2'd2: misalign_d = |req_addr[1:0];
      default: misalign_d = 1'b1;
    endcase
  end

  // A channel counts as done once its valid has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || m_awready;
  assign w_done  = !wvalid_q  || m_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_q      <= req_addr;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            if (misalign_d) begin
              rdata_q     <= '0;
              err_q       <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (req_wen) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_rvalid) begin
            rready_q    <= 1'b0;
            rdata_q     <= m_rdata >> {addr_q[1:0], 3'b000};
            err_q       <= |m_rresp;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WR_REQ: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_bvalid) begin
            bready_q    <= 1'b0;
            rdata_q     <= '0;
            err_q       <= |m_bresp;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign m_arvalid = arvalid_q;
  assign m_araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_rready  = rready_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = strb_q;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_riscv_lsu_axi_bridge.sv
// Directed vector table plus hand-written multi-cycle sequences for the LSU AXI bridge.
module tb_riscv_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  riscv_lsu_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] s_rdata;
    logic [1:0]  s_resp;
    logic        exp_bus;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic [31:0] s_rdata, input logic [1:0] s_resp,
                              input logic exp_bus, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input logic exp_err, input int exp_lat);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size;
    v.s_rdata = s_rdata; v.s_resp = s_resp; v.exp_bus = exp_bus; v.exp_addr = exp_addr;
    v.exp_strb = exp_strb; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) chk({name, "_req_ready_timeout"}, 0, 1);
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    @(posedge clk);
  endtask

  task automatic run_vec(input int i);
    vec_t v = vecs[i];
    int   lat = 0;
    logic bus = 1'b0;
    logic [31:0] addr_seen = '0, wdata_seen = '0, rdata_seen = '0;
    logic [3:0]  strb_seen = '0;
    logic        err_seen = 1'b0;
    wait_ready($sformatf("v%0d", i));
    issue(v.wen, v.addr, v.wdata, v.size);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (m_arvalid && (m_awvalid || m_wvalid)) overlap++;
      if (m_arvalid) begin bus = 1'b1; addr_seen = m_araddr; end
      if (m_awvalid) begin bus = 1'b1; addr_seen = m_awaddr; end
      if (m_wvalid)  begin bus = 1'b1; wdata_seen = m_wdata; strb_seen = m_wstrb; end
      m_rvalid = m_rready;
      m_rdata  = v.s_rdata;
      m_rresp  = v.s_resp;
      m_bvalid = m_bready;
      m_bresp  = v.s_resp;
      if (rsp_valid) begin
        lat = c;
        rdata_seen = rsp_rdata;
        err_seen = rsp_err;
        break;
      end
    end
    @(negedge clk);
    chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
    chk($sformatf("v%0d_rdata", i), rdata_seen, v.exp_rdata);
    chk($sformatf("v%0d_err", i), {31'b0, err_seen}, {31'b0, v.exp_err});
    chk($sformatf("v%0d_bus_traffic", i), {31'b0, bus}, {31'b0, v.exp_bus});
    if (v.exp_bus) chk($sformatf("v%0d_addr", i), addr_seen, v.exp_addr);
    if (v.exp_bus && v.wen) begin
      chk($sformatf("v%0d_wstrb", i), {28'b0, strb_seen}, {28'b0, v.exp_strb});
      chk($sformatf("v%0d_wdata", i), wdata_seen, v.exp_wdata);
    end
  endtask

  initial begin
    logic [31:0] held;
    int aw_cnt, w_cnt, rsp_cnt, bad_stable, bad_ready, seen;

    //               wen   addr          wdata         sz    s_rdata       rsp   bus  exp_addr      strb     exp_wdata     exp_rdata     err  lat
    vecs[0]  = mk(1'b0, 32'h8000_0004, 32'h0,        2'd2, 32'hDEAD_BEEF, 2'b00, 1'b1, 32'h8000_0004, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 3);
    vecs[1]  = mk(1'b0, 32'h8000_0003, 32'h0,        2'd0, 32'h1122_3344, 2'b00, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_0011, 1'b0, 3);
    vecs[2]  = mk(1'b0, 32'h8000_0002, 32'h0,        2'd1, 32'h1122_3344, 2'b00, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h0000_1122, 1'b0, 3);
    vecs[3]  = mk(1'b1, 32'h8000_0001, 32'hFFFF_FFAB, 2'd0, 32'h0,       2'b00, 1'b1, 32'h8000_0000, 4'b0010, 32'hABAB_ABAB, 32'h0,        1'b0, 3);
    vecs[4]  = mk(1'b1, 32'h8000_0002, 32'h5555_1234, 2'd1, 32'h0,       2'b00, 1'b1, 32'h8000_0000, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 3);
    vecs[5]  = mk(1'b1, 32'h8000_0008, 32'hCAFE_F00D, 2'd2, 32'h0,       2'b00, 1'b1, 32'h8000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 3);
    vecs[6]  = mk(1'b0, 32'h8000_0002, 32'h0,        2'd2, 32'h0,        2'b00, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1);
    vecs[7]  = mk(1'b0, 32'h8000_0000, 32'h0,        2'd2, 32'h1234_5678, 2'b10, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h1234_5678, 1'b1, 3);
    vecs[8]  = mk(1'b1, 32'h8000_000C, 32'h0000_0077, 2'd2, 32'h0,       2'b11, 1'b1, 32'h8000_000C, 4'b1111, 32'h0000_0077, 32'h0,        1'b1, 3);
    vecs[9]  = mk(1'b0, 32'h8000_0000, 32'h0,        2'd3, 32'h0,        2'b00, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1);
    vecs[10] = mk(1'b1, 32'h8000_0001, 32'h0000_BEEF, 2'd1, 32'h0,       2'b00, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0,         1'b1, 1);
    vecs[11] = mk(1'b0, 32'h8000_0001, 32'h0,        2'd0, 32'hA1B2_C3D4, 2'b00, 1'b1, 32'h8000_0000, 4'b0000, 32'h0,        32'h00A1_B2C3, 1'b0, 3);

    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_size = '0;
    rsp_ready = 1'b1;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bvalid = 1'b0; m_bresp = '0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #3;
    chk("reset_ctrl", {24'b0, req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_addr", m_araddr | m_awaddr, 0);
    chk("reset_wdata_strb", m_wdata | {28'b0, m_wstrb}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", {31'b0, req_ready}, 1);

    for (int i = 0; i < 12; i++) run_vec(i);
    chk("ar_aw_overlap", overlap, 0);

    // Store with AW stalled three cycles while W completes immediately.
    wait_ready("seqA");
    m_awready = 1'b0;
    issue(1'b1, 32'h8000_0010, 32'h0000_00EE, 2'd0);
    aw_cnt = 0; w_cnt = 0; rsp_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (m_awvalid) aw_cnt++;
      if (m_wvalid) w_cnt++;
      if (m_awvalid && aw_cnt == 4) m_awready = 1'b1;
      m_bvalid = m_bready;
      m_bresp  = 2'b00;
      if (rsp_valid) rsp_cnt++;
    end
    m_awready = 1'b1;
    chk("seqA_wvalid_cycles", w_cnt, 1);
    chk("seqA_awvalid_cycles", aw_cnt, 4);
    chk("seqA_responses", rsp_cnt, 1);

    // Response stalled by the LSU for five cycles.
    wait_ready("seqB");
    rsp_ready = 1'b0;
    issue(1'b0, 32'h8000_0020, 32'h0, 2'd2);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      m_rvalid = m_rready;
      m_rdata  = 32'h0BAD_F00D;
      m_rresp  = 2'b00;
      if (rsp_valid) begin seen = 1; break; end
    end
    chk("seqB_rsp_seen", seen, 1);
    held = rsp_rdata;
    chk("seqB_rdata", held, 32'h0BAD_F00D);
    bad_stable = 0; bad_ready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== held) bad_stable++;
      if (req_ready) bad_ready++;
    end
    chk("seqB_held_stable", bad_stable, 0);
    chk("seqB_req_ready_low", bad_ready, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("seqB_rsp_dropped", {31'b0, rsp_valid}, 0);
    chk("seqB_req_ready_back", {31'b0, req_ready}, 1);

    // Reset pulled while the read data phase is pending.
    wait_ready("seqC");
    m_rvalid = 1'b0;
    issue(1'b0, 32'h8000_0030, 32'h0, 2'd2);
    seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (m_rready) begin seen = 1; break; end
    end
    chk("seqC_in_rd_data", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("seqC_rst_ctrl", {24'b0, req_ready, rsp_valid, rsp_err, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    chk("seqC_rst_rdata", rsp_rdata, 0);
    chk("seqC_rst_addr", m_araddr | m_awaddr, 0);
    chk("seqC_rst_wdata_strb", m_wdata | {28'b0, m_wstrb}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("seqC_req_ready_after", {31'b0, req_ready}, 1);
    rsp_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    chk("seqC_no_response", rsp_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
